// File: rtl/cnn_int4_pkg.sv
// cnn_int4_pkg
// Shared definitions for the int4 CNN datapath: int4 range limits,
// accumulator and packed-word widths, the output-frame FSM state type and
// a helper that builds the round-half-up constant for a given shift.
package cnn_int4_pkg;

  localparam int INT4_MAX     = 7;
  localparam int INT4_MIN     = -8;
  localparam int ACC_W        = 15;
  localparam int WORD_W       = 32;
  localparam int NIB_PER_WORD = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } frame_state_t;

  // Half an output LSB, added before the arithmetic shift; zero when no shift.
  function automatic logic signed [15:0] round_const(input int sh);
    if (sh > 0) begin
      return 16'sd1 <<< (sh - 1);
    end
    return '0;
  endfunction

endpackage

// File: rtl/requant_int4.sv
// requant_int4
// Requantises one 15-bit accumulated sum to int4: round half up, arithmetic
// right shift by SHIFT, then saturate. Result is registered with its valid.
// Optional feature macro: CONV_RELU_EN (clamps negative sums to zero before
// the shift, so results lie in [0, 7]).
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - synchronous active-low reset
//   in_valid - sum is valid this cycle
//   sum      - signed accumulator value
//   q        - registered int4 result (two's complement nibble)
//   q_valid  - q holds a new result
module requant_int4
  import cnn_int4_pkg::*;
#(
  parameter int SHIFT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic signed [ACC_W-1:0] sum,
  output logic [3:0]              q,
  output logic                    q_valid
);

  localparam logic signed [15:0] RND   = round_const(SHIFT);
  localparam logic signed [15:0] Q_MAX = 16'(INT4_MAX);
  localparam logic signed [15:0] Q_MIN = 16'(INT4_MIN);

  logic signed [15:0] ext;
  logic signed [15:0] biased;
  logic signed [15:0] shifted;
  logic [3:0]         q_next;

  // 16 bits leave headroom for the rounding add on the largest 15-bit sum.
  always_comb begin
    ext = {sum[ACC_W-1], sum};
`ifdef CONV_RELU_EN
    if (ext[15]) begin
      ext = '0;
    end
`endif
    biased  = ext + RND;
    shifted = biased >>> SHIFT;
    if (shifted > Q_MAX) begin
      q_next = Q_MAX[3:0];
    end else if (shifted < Q_MIN) begin
      q_next = Q_MIN[3:0];
    end else begin
      q_next = shifted[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      q_valid <= in_valid;
      if (in_valid) begin
        q <= q_next;
      end
    end
  end

endmodule

// File: rtl/conv_requant_pack.sv
// conv_requant_pack
// Output stage after the 9-input adder tree: aligns in_valid with the tree
// latency, requantises each sum to int4, packs eight nibbles per 32-bit word
// and writes them to the output feature-map RAM at incrementing addresses.
// A frame ends after PIX_PER_FRAME pixels; any partial word is flushed with
// zero padding and frame_done pulses once.
// Optional feature macro: CONV_RELU_EN (passed through to requant_int4).
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - synchronous active-low reset
//   start      - single-cycle pulse, arms a frame (only honoured in IDLE)
//   in_valid   - adder-tree inputs presented this cycle
//   sum        - adder-tree result, ADD_LAT cycles after in_valid
//   wr_en      - RAM write strobe
//   wr_addr    - RAM word address
//   wr_data    - packed nibbles, pixel k in bits [4k+3:4k]
//   busy       - frame in progress (RUN or FLUSH)
//   frame_done - one-cycle pulse after the last word of a frame
//
// state | meaning
// IDLE  | waiting for start; pixels ignored
// RUN   | accepting pixels until PIX_PER_FRAME have been taken
// FLUSH | write the partial word if any nibbles are pending
// DONE  | frame complete; frame_done pulses the following cycle
module conv_requant_pack
  import cnn_int4_pkg::*;
#(
  parameter int SHIFT         = 4,
  parameter int ADD_LAT       = 2,
  parameter int PIX_PER_FRAME = 676,
  parameter int ADDR_W        = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic signed [ACC_W-1:0] sum,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [WORD_W-1:0]       wr_data,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int PIX_W = $clog2(PIX_PER_FRAME + 1);

  frame_state_t state, state_nx;

  logic [ADD_LAT-1:0] vld_dly;
  logic               sum_valid;
  logic [PIX_W-1:0]   pix_cnt;
  logic               frame_full;
  logic               accept;
  logic [3:0]         nib;
  logic               nib_valid;
  logic [2:0]         nib_idx;
  logic [WORD_W-1:0]  pack_reg;
  logic [WORD_W-1:0]  pack_next;
  logic [ADDR_W-1:0]  word_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_dly <= '0;
    end else begin
      vld_dly <= (vld_dly << 1) | ADD_LAT'(in_valid);
    end
  end

  assign sum_valid  = vld_dly[ADD_LAT-1];
  assign frame_full = (pix_cnt == PIX_W'(PIX_PER_FRAME));
  assign accept     = (state == RUN) && sum_valid && !frame_full;

  requant_int4 #(
    .SHIFT(SHIFT)
  ) u_requant (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(accept),
    .sum     (sum),
    .q       (nib),
    .q_valid (nib_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // The last accepted nibble leaves stage R in the same cycle frame_full
  // first reads true, so FLUSH already sees the final nibble index.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (frame_full) begin
          state_nx = FLUSH;
        end
      end
      FLUSH: begin
        busy     = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    pack_next = pack_reg;
    pack_next[{nib_idx, 2'b00} +: 4] = nib;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_cnt    <= '0;
      word_cnt   <= '0;
      nib_idx    <= '0;
      pack_reg   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= (state == DONE);
      if ((state == IDLE) && start) begin
        pix_cnt  <= '0;
        word_cnt <= '0;
        nib_idx  <= '0;
        pack_reg <= '0;
      end else begin
        if (accept) begin
          pix_cnt <= pix_cnt + 1'b1;
        end
        if (nib_valid) begin
          nib_idx <= nib_idx + 1'b1;
          if (nib_idx == 3'd7) begin
            wr_en    <= 1'b1;
            wr_data  <= pack_next;
            wr_addr  <= word_cnt;
            word_cnt <= word_cnt + 1'b1;
            // Cleared so a later partial word carries zero padding.
            pack_reg <= '0;
          end else begin
            pack_reg <= pack_next;
          end
        end else if ((state == FLUSH) && (nib_idx != 3'd0)) begin
          wr_en    <= 1'b1;
          wr_data  <= pack_reg;
          wr_addr  <= word_cnt;
          word_cnt <= word_cnt + 1'b1;
          nib_idx  <= '0;
          pack_reg <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_requant_pack.sv
module tb_conv_requant_pack;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               in_valid;
  logic signed [14:0] sum;
  logic signed [14:0] raw;
  logic signed [14:0] raw_d1;
  logic               wr_en;
  logic [6:0]         wr_addr;
  logic [31:0]        wr_data;
  logic               busy;
  logic               frame_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_in = 0;
  int fd_cnt = 0;
  int fd_cyc = 0;

  logic [31:0] wd_q[$];
  logic [6:0]  wa_q[$];
  int          wc_q[$];

  conv_requant_pack #(
    .SHIFT(4),
    .ADD_LAT(2),
    .PIX_PER_FRAME(10),
    .ADDR_W(7)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .in_valid(in_valid),
    .sum(sum),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Stand-in for the adder tree: sum follows the presented operands by 2 cycles.
  always @(posedge clk) begin
    raw_d1 <= raw;
    sum    <= raw_d1;
  end

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (wr_en === 1'b1) begin
      wd_q.push_back(wr_data);
      wa_q.push_back(wr_addr);
      wc_q.push_back(cyc);
    end
    if (frame_done === 1'b1) begin
      fd_cnt = fd_cnt + 1;
      fd_cyc = cyc;
    end
  end

  task automatic clear_log;
    wd_q.delete();
    wa_q.delete();
    wc_q.delete();
  endtask

  task automatic feed_raw(input logic signed [14:0] s);
    @(negedge clk);
    in_valid = 1'b1;
    raw      = s;
    last_in  = cyc;
  endtask

  task automatic feed_q(input int q);
    feed_raw(15'(q * 16));
  endtask

  task automatic idle_in;
    @(negedge clk);
    in_valid = 1'b0;
    raw      = '0;
  endtask

  task automatic do_start;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_frame(input int fd0);
    for (int i = 0; i < 60 && fd_cnt == fd0; i++) @(negedge clk);
    checks++;
    if (fd_cnt == fd0) begin
      errors++;
      $display("FAIL frame_timeout: frame_done count %0d required > %0d", fd_cnt, fd0);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; raw = '0;
    repeat (4) @(negedge clk);
    checks += 5;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
    if (wr_addr !== 7'd0) begin errors++; $display("FAIL rst_wr_addr: got %0d want 0", wr_addr); end
    if (wr_data !== 32'd0) begin errors++; $display("FAIL rst_wr_data: got %h want 0", wr_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rounding;
    int fd0;
    logic [31:0] exp0;
`ifdef CONV_RELU_EN
    exp0 = 32'h0000_0702;
`else
    exp0 = 32'h0000_87F2;
`endif
    clear_log();
    fd0 = fd_cnt;
    do_start();
    feed_raw(15'sd24);
    feed_raw(-15'sd24);
    feed_raw(15'sd16383);
    feed_raw(-15'sd16384);
    feed_raw(-15'sd5);
    for (int i = 0; i < 5; i++) feed_raw(15'sd0);
    idle_in();
    wait_frame(fd0);
    checks += 5;
    if (wd_q.size() !== 2) begin errors++; $display("FAIL round_nwrites: got %0d want 2", wd_q.size()); end
    if (wd_q[0] !== exp0) begin errors++; $display("FAIL round_word0: got %h want %h", wd_q[0], exp0); end
    if (wa_q[0] !== 7'd0) begin errors++; $display("FAIL round_addr0: got %0d want 0", wa_q[0]); end
    if (wd_q[1] !== 32'h0) begin errors++; $display("FAIL round_word1: got %h want 0", wd_q[1]); end
    if (wa_q[1] !== 7'd1) begin errors++; $display("FAIL round_addr1: got %0d want 1", wa_q[1]); end
  endtask

  task automatic test_packing;
    int fd0;
    int m8;
    clear_log();
    fd0 = fd_cnt;
    do_start();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL pack_busy_rise: got %b want 1", busy); end
    for (int q = 1; q <= 8; q++) feed_q(q);
    m8 = last_in;
    feed_q(5);
    feed_q(6);
    idle_in();
    wait_frame(fd0);
    checks += 6;
    if (wd_q.size() !== 2) begin errors++; $display("FAIL pack_nwrites: got %0d want 2", wd_q.size()); end
    if (wd_q[0] !== 32'h7765_4321) begin errors++; $display("FAIL pack_word0: got %h want 77654321", wd_q[0]); end
    if (wa_q[0] !== 7'd0) begin errors++; $display("FAIL pack_addr0: got %0d want 0", wa_q[0]); end
    if (wc_q[0] !== m8 + 4) begin errors++; $display("FAIL pack_latency: got cycle %0d want %0d", wc_q[0], m8 + 4); end
    if (wd_q[1] !== 32'h0000_0065) begin errors++; $display("FAIL pack_word1: got %h want 00000065", wd_q[1]); end
    if (wa_q[1] !== 7'd1) begin errors++; $display("FAIL pack_addr1: got %0d want 1", wa_q[1]); end
  endtask

  task automatic test_partial_flush;
    int fd0;
    int m10;
    clear_log();
    fd0 = fd_cnt;
    do_start();
    for (int i = 0; i < 10; i++) feed_q(3);
    m10 = last_in;
    idle_in();
    wait_frame(fd0);
    checks += 8;
    if (wd_q.size() !== 2) begin errors++; $display("FAIL flush_nwrites: got %0d want 2", wd_q.size()); end
    if (wd_q[0] !== 32'h3333_3333) begin errors++; $display("FAIL flush_word0: got %h want 33333333", wd_q[0]); end
    if (wd_q[1] !== 32'h0000_0033) begin errors++; $display("FAIL flush_word1: got %h want 00000033", wd_q[1]); end
    if (wa_q[1] !== 7'd1) begin errors++; $display("FAIL flush_addr1: got %0d want 1", wa_q[1]); end
    if (wc_q[1] !== m10 + 5) begin errors++; $display("FAIL flush_wr_cycle: got %0d want %0d", wc_q[1], m10 + 5); end
    if (fd_cyc !== m10 + 6) begin errors++; $display("FAIL flush_done_cycle: got %0d want %0d", fd_cyc, m10 + 6); end
    if (fd_cnt !== fd0 + 1) begin errors++; $display("FAIL flush_done_count: got %0d want %0d", fd_cnt, fd0 + 1); end
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_fall: got %b want 0", busy); end
  endtask

  task automatic test_overrun_start;
    int fd0;
    clear_log();
    fd0 = fd_cnt;
    do_start();
    for (int i = 0; i < 12; i++) begin
      feed_q(1);
      start = (i == 4);
    end
    idle_in();
    start = 1'b0;
    wait_frame(fd0);
    repeat (5) @(negedge clk);
    checks += 6;
    if (wd_q.size() !== 2) begin errors++; $display("FAIL over_nwrites: got %0d want 2", wd_q.size()); end
    if (wd_q[0] !== 32'h1111_1111) begin errors++; $display("FAIL over_word0: got %h want 11111111", wd_q[0]); end
    if (wa_q[0] !== 7'd0) begin errors++; $display("FAIL over_addr0: got %0d want 0", wa_q[0]); end
    if (wd_q[1] !== 32'h0000_0011) begin errors++; $display("FAIL over_word1: got %h want 00000011", wd_q[1]); end
    if (wa_q[1] !== 7'd1) begin errors++; $display("FAIL over_addr1: got %0d want 1", wa_q[1]); end
    if (fd_cnt !== fd0 + 1) begin errors++; $display("FAIL over_done_count: got %0d want %0d", fd_cnt, fd0 + 1); end
  endtask

  task automatic test_reset_mid;
    int fd0;
    clear_log();
    do_start();
    for (int i = 0; i < 5; i++) feed_q(4);
    @(negedge clk);
    in_valid = 1'b0;
    raw      = '0;
    rst_n    = 1'b0;
    @(negedge clk);
    checks += 4;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL mid_rst_wr_en: got %b want 0", wr_en); end
    if (wr_addr !== 7'd0) begin errors++; $display("FAIL mid_rst_wr_addr: got %0d want 0", wr_addr); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL mid_rst_frame_done: got %b want 0", frame_done); end
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (wd_q.size() !== 0) begin errors++; $display("FAIL mid_rst_no_write: got %0d writes want 0", wd_q.size()); end
    clear_log();
    fd0 = fd_cnt;
    do_start();
    for (int i = 0; i < 10; i++) feed_q(2);
    idle_in();
    wait_frame(fd0);
    checks += 4;
    if (wd_q.size() !== 2) begin errors++; $display("FAIL mid_restart_nwrites: got %0d want 2", wd_q.size()); end
    if (wd_q[0] !== 32'h2222_2222) begin errors++; $display("FAIL mid_restart_word0: got %h want 22222222", wd_q[0]); end
    if (wa_q[0] !== 7'd0) begin errors++; $display("FAIL mid_restart_addr0: got %0d want 0", wa_q[0]); end
    if (wd_q[1] !== 32'h0000_0022) begin errors++; $display("FAIL mid_restart_word1: got %h want 00000022", wd_q[1]); end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_packing();
    test_partial_flush();
    test_overrun_start();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
